bus_arbiter: RTL and testbench

Two-master arbiter placed in front of the system bridge: it shares the single processor-side bus (address, write data, write enable, read data) between the CPU M-stage and the DMA engine. CPU has default priority; DMA gets bounded bursts and an anti-starvation guarantee. Address decode for error flagging uses the system map: DM 0x0000_0000–0x0000_2FFF, DEV0 0x0000_7F00–0x0000_7F0B, DEV1 0x0000_7F10–0x0000_7F1B.

---
 rtl/bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the processor-side bus between the CPU M-stage and
// the DMA engine. The CPU owns the bus by default. The DMA engine is forced
// onto the bus after a bounded wait, and its tenure is capped at MAX_BURST
// beats, after which the CPU gets at least one guaranteed cycle.
// Ownership comes from registered state only. Every output is derived
// combinationally from that state and the current inputs.

module bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 32'd8,
    parameter int unsigned MAX_BURST    = 32'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_last,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wd,
    output logic        dma_gnt,
    output logic [31:0] dma_rd,
    output logic        dma_err,
    output logic [31:0] PrAddr,
    output logic [31:0] PrWD,
    output logic        PrWE,
    input  logic [31:0] PrRD
);

    // The starvation counter only needs to reach STARVE_LIMIT-1, because
    // the hand-over happens at that value. The beat counter must hold a
    // full MAX_BURST.
    localparam int unsigned SW = (STARVE_LIMIT > 32'd1) ? $clog2(STARVE_LIMIT) : 32'd1;
    localparam int unsigned BW = $clog2(MAX_BURST + 32'd1);

    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 32'd1);
    localparam logic [BW-1:0] BURST_LAST  = BW'(MAX_BURST - 32'd1);

    typedef enum logic [1:0] {
        S_CPU   = 2'd0,
        S_DMA   = 2'd1,
        S_YIELD = 2'd2
    } state_t;

    state_t          state_r;
    logic [SW-1:0]   starve_cnt_r;
    logic [BW-1:0]   beat_cnt_r;

    logic            dma_owns_s;
    logic            cpu_mapped_s;
    logic            dma_mapped_s;

    // System map: DM, DEV0 and DEV1 windows; everything else is unmapped.
    function automatic logic addr_mapped(input logic [31:0] a);
        logic hit;
        hit = 1'b0;
        if (a <= 32'h0000_2FFF) begin
            hit = 1'b1;
        end else if ((a >= 32'h0000_7F00) && (a <= 32'h0000_7F0B)) begin
            hit = 1'b1;
        end else if ((a >= 32'h0000_7F10) && (a <= 32'h0000_7F1B)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Ownership FSM with the starvation and burst-length counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_CPU;
            starve_cnt_r <= '0;
            beat_cnt_r   <= '0;
        end else begin
            case (state_r)
                S_CPU: begin
                    beat_cnt_r <= '0;
                    if (dma_req == 1'b0) begin
                        starve_cnt_r <= '0;
                        state_r      <= S_CPU;
                    end else if ((cpu_req == 1'b0) || (starve_cnt_r == STARVE_LAST)) begin
                        starve_cnt_r <= '0;
                        state_r      <= S_DMA;
                    end else begin
                        starve_cnt_r <= starve_cnt_r + SW'(1);
                        state_r      <= S_CPU;
                    end
                end
                S_DMA: begin
                    starve_cnt_r <= '0;
                    if (dma_req == 1'b0) begin
                        state_r <= S_CPU;
                    end else begin
                        beat_cnt_r <= beat_cnt_r + BW'(1);
                        // A last beat ends the tenure even if it also hits the cap.
                        if (dma_last == 1'b1) begin
                            state_r <= S_CPU;
                        end else if (beat_cnt_r == BURST_LAST) begin
                            state_r <= S_YIELD;
                        end else begin
                            state_r <= S_DMA;
                        end
                    end
                end
                S_YIELD: begin
                    starve_cnt_r <= '0;
                    beat_cnt_r   <= '0;
                    state_r      <= S_CPU;
                end
                default: begin
                    starve_cnt_r <= '0;
                    beat_cnt_r   <= '0;
                    state_r      <= S_CPU;
                end
            endcase
        end
    end

    // Bus steering and handshakes. The reset gating keeps grant and write
    // enable low for the whole time reset is high.
    always_comb begin
        dma_owns_s   = (state_r == S_DMA);
        cpu_mapped_s = addr_mapped(cpu_addr);
        dma_mapped_s = addr_mapped(dma_addr);

        PrAddr    = 32'h0000_0000;
        PrWD      = 32'h0000_0000;
        PrWE      = 1'b0;
        cpu_rd    = 32'h0000_0000;
        dma_rd    = 32'h0000_0000;
        cpu_stall = 1'b0;
        dma_gnt   = 1'b0;
        dma_err   = 1'b0;

        if (dma_owns_s) begin
            PrAddr = dma_addr;
            PrWD   = dma_wd;
            dma_rd = PrRD;
        end else begin
            PrAddr = cpu_addr;
            PrWD   = cpu_wd;
            cpu_rd = PrRD;
        end

        if (reset) begin
            PrWE      = 1'b0;
            cpu_stall = 1'b0;
            dma_gnt   = 1'b0;
            dma_err   = 1'b0;
        end else if (dma_owns_s) begin
            PrWE      = dma_req & dma_we & dma_mapped_s;
            cpu_stall = cpu_req;
            dma_gnt   = dma_req;
            dma_err   = dma_req & ~dma_mapped_s;
        end else begin
            PrWE      = cpu_req & cpu_we & cpu_mapped_s;
            cpu_stall = 1'b0;
            dma_gnt   = 1'b0;
            dma_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: runs directed scenarios and a randomized phase against
// bus_arbiter. A behavioural ownership model predicts the outputs on every
// cycle.
module tb_bus_arbiter;

    localparam int SL = 8;
    localparam int MB = 16;
    localparam int OWN_CPU   = 0;
    localparam int OWN_DMA   = 1;
    localparam int OWN_YIELD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_last;
    logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd, PrRD;
    logic [31:0] cpu_rd, dma_rd, PrAddr, PrWD;
    logic        cpu_stall, dma_gnt, dma_err, PrWE;

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the bus, how long DMA has waited, and how
    // many beats the current tenure has moved.
    int m_owner;
    int m_waited;
    int m_beats;

    always #5 clk = ~clk;

    bus_arbiter #(.STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last),
        .dma_addr(dma_addr), .dma_wd(dma_wd),
        .dma_gnt(dma_gnt), .dma_rd(dma_rd), .dma_err(dma_err),
        .PrAddr(PrAddr), .PrWD(PrWD), .PrWE(PrWE), .PrRD(PrRD)
    );

    function automatic bit in_map(input logic [31:0] a);
        return (a < 32'h3000) ||
               ((a >= 32'h7F00) && (a < 32'h7F0C)) ||
               ((a >= 32'h7F10) && (a < 32'h7F1C));
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 6))
            0: a = 32'($urandom_range(0, 32'h0BFF)) << 2;
            1: a = 32'h7F00 + 32'($urandom_range(0, 11));
            2: a = 32'h7F10 + 32'($urandom_range(0, 11));
            3: a = 32'h7F0C;
            4: a = 32'h7F1C;
            5: a = 32'h3000;
            default: a = $urandom;
        endcase
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = OWN_CPU;
        m_waited = 0;
        m_beats  = 0;
    endtask

    // Let the inputs settle, then compare every output with the model.
    task automatic settle();
        bit own_dma, e_gnt, e_stall, e_err, e_we;
        PrRD = $urandom;
        #1;
        if (reset) model_reset();
        own_dma = (m_owner == OWN_DMA);
        e_gnt   = !reset && dma_req && own_dma;
        e_stall = !reset && cpu_req && own_dma;
        e_err   = e_gnt && !in_map(dma_addr);
        if (own_dma) e_we = dma_req && dma_we && in_map(dma_addr);
        else         e_we = cpu_req && cpu_we && in_map(cpu_addr);
        e_we = e_we && !reset;
        chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        chk("dma_gnt",   32'(dma_gnt),   32'(e_gnt));
        chk("dma_err",   32'(dma_err),   32'(e_err));
        chk("PrWE",      32'(PrWE),      32'(e_we));
        chk("PrAddr",    PrAddr, own_dma ? dma_addr : cpu_addr);
        chk("PrWD",      PrWD,   own_dma ? dma_wd : cpu_wd);
        chk("cpu_rd",    cpu_rd, own_dma ? 32'd0 : PrRD);
        chk("dma_rd",    dma_rd, own_dma ? PrRD : 32'd0);
    endtask

    // Step the model across one rising edge, then return to the falling edge.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (m_owner == OWN_CPU) begin
            if (!dma_req) begin
                m_waited = 0;
            end else if (!cpu_req || (m_waited + 1 >= SL)) begin
                m_owner  = OWN_DMA;
                m_waited = 0;
                m_beats  = 0;
            end else begin
                m_waited++;
            end
        end else if (m_owner == OWN_DMA) begin
            if (!dma_req) begin
                m_owner = OWN_CPU;
            end else begin
                m_beats++;
                if (dma_last)          m_owner = OWN_CPU;
                else if (m_beats == MB) m_owner = OWN_YIELD;
            end
        end else begin
            m_owner = OWN_CPU;
        end
        @(negedge clk);
    endtask

    // Keep cpu_req and dma_req as they are and count cycles up to the first DMA grant.
    task automatic first_grant(output int first);
        int i;
        first = -1;
        i = 0;
        while ((first < 0) && (i < 40)) begin
            settle();
            if (i == 0) chk("wait_start_stall", 32'(cpu_stall), 32'd0);
            if (dma_gnt === 1'b1) begin
                first = i;
                chk("forced_grant_stall", 32'(cpu_stall), 32'd1);
            end
            advance();
            i++;
        end
    endtask

    initial begin
        int first;
        int beats;
        int gc[32];

        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wd = 32'h55;
        dma_req = 1'b1; dma_we = 1'b1; dma_last = 1'b0; dma_addr = 32'h200; dma_wd = 32'h66;
        PrRD = 32'h0;
        model_reset();
        @(negedge clk);

        // Reset holds the handshakes low whatever the requesters do.
        settle();
        chk("rst_PrWE", 32'(PrWE), 32'd0);
        chk("rst_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        advance();
        settle();
        advance();
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0;

        // CPU store while DMA is idle.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wd = 32'h1234;
        settle();
        chk("sw_PrWE", 32'(PrWE), 32'd1);
        chk("sw_PrAddr", PrAddr, 32'h100);
        chk("sw_PrWD", PrWD, 32'h1234);
        chk("sw_stall", 32'(cpu_stall), 32'd0);
        advance();

        // Starvation: the CPU keeps requesting, so DMA is forced in after SL cycles.
        cpu_we = 1'b0; cpu_addr = 32'h40;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200;
        first_grant(first);
        chk("starve_first_gnt", 32'(first), 32'(SL));
        dma_req = 1'b0;
        settle();
        advance();

        // Four-beat DMA write burst to DEV0 while the CPU is idle.
        cpu_req = 1'b0;
        dma_we = 1'b1;
        beats = 0;
        for (int c = 0; c < 7; c++) begin
            dma_req  = (beats < 4);
            dma_addr = 32'h7F00 + 32'(4 * (beats % 3));
            dma_last = (beats == 3);
            dma_wd   = $urandom;
            if (c == 5) cpu_req = 1'b1;
            settle();
            chk("burst_gnt", 32'(dma_gnt), ((c >= 1) && (c <= 4)) ? 32'd1 : 32'd0);
            if (c == 5) chk("burst_back_to_cpu", 32'(cpu_stall), 32'd0);
            if (dma_gnt === 1'b1) beats++;
            advance();
        end
        chk("burst_beats", 32'(beats), 32'd4);

        // 20-beat burst with the CPU always requesting: the burst is capped,
        // the CPU gets one yield cycle, and DMA waits again.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        dma_req = 1'b1; dma_we = 1'b0;
        for (int k = 0; k < 32; k++) gc[k] = -1;
        beats = 0;
        for (int c = 0; c < 120; c++) begin
            if (beats < 20) begin
                dma_last = (beats == 19);
                dma_addr = 32'h1000 + 32'(4 * beats);
                settle();
                if (c == 24) begin
                    chk("yield_stall", 32'(cpu_stall), 32'd0);
                    chk("yield_gnt", 32'(dma_gnt), 32'd0);
                end
                if (dma_gnt === 1'b1) begin
                    gc[beats] = c;
                    beats++;
                end
                advance();
            end
        end
        chk("cap_beats", 32'(beats), 32'd20);
        chk("cap_first", 32'(gc[0]), 32'd8);
        chk("cap_16th", 32'(gc[15]), 32'd23);
        chk("cap_regrant", 32'(gc[16]), 32'd33);
        chk("cap_last", 32'(gc[19]), 32'd36);
        dma_req = 1'b0; dma_last = 1'b0;
        settle();
        advance();

        // DMA write to an unmapped address: the beat is granted and flagged,
        // and nothing is written.
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h5000; dma_last = 1'b1; dma_wd = 32'hDEAD;
        settle();
        chk("unmap_c0_gnt", 32'(dma_gnt), 32'd0);
        advance();
        settle();
        chk("unmap_gnt", 32'(dma_gnt), 32'd1);
        chk("unmap_err", 32'(dma_err), 32'd1);
        chk("unmap_PrWE", 32'(PrWE), 32'd0);
        advance();
        dma_req = 1'b0; dma_last = 1'b0;
        settle();
        advance();

        // Reset arrives during beat 3 of a burst.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h2000; dma_last = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            advance();
        end
        settle();
        chk("beat3_gnt", 32'(dma_gnt), 32'd1);
        chk("beat3_PrWE", 32'(PrWE), 32'd1);
        reset = 1'b1;
        settle();
        chk("midrst_gnt", 32'(dma_gnt), 32'd0);
        chk("midrst_PrWE", 32'(PrWE), 32'd0);
        chk("midrst_err", 32'(dma_err), 32'd0);
        advance();
        reset = 1'b0;
        cpu_req = 1'b1;
        first_grant(first);
        chk("postrst_first_gnt", 32'(first), 32'(SL));
        dma_req = 1'b0;
        settle();
        advance();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 299) == 0);
            cpu_req  = 1'($urandom_range(0, 1));
            cpu_we   = 1'($urandom_range(0, 1));
            cpu_addr = pick_addr();
            cpu_wd   = $urandom;
            dma_req  = ($urandom_range(0, 7) != 0);
            dma_we   = 1'($urandom_range(0, 1));
            dma_last = ($urandom_range(0, 9) == 0);
            dma_addr = pick_addr();
            dma_wd   = $urandom;
            settle();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
